cu_param: RTL and testbench

//  Parametrised control unit (FSM) for the accumulator processor datapath.

---
 rtl/cu_param.sv | 195 +++++++++++++++++++
 tb/tb_cu_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cu_param.sv
// Purpose : parametrised fetch/decode/execute control unit for the accumulator datapath.
// Latency : START 1, FETCH MEM_LAT+1, DECODE 1, LOAD/ADD/SUB MEM_LAT+1, others 1 (IN/HALT wait on Enter).
// Backpress: none; IN and HALT stall until an Enter rising edge, memory wait states are fixed by MEM_LAT.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   Enter                  board switch level; only its rising edge is acted on
//   Aeq0, Apos             A register status flags used by JZ / JPOS
//   IR[OPW-1:0]            opcode field of the instruction register
//   IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Asel[1:0]
//                          datapath controls decoded from the current state
//   illegal_op             sticky flag: an opcode >= 10 reached DECODE
//   state_o[3:0]           current state encoding for debug

module cu_param #(
  parameter int OPW       = 4,
  parameter int MEM_LAT   = 1,
  parameter int RESUME_EN = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           Enter,
  input  logic           Aeq0,
  input  logic           Apos,
  input  logic [OPW-1:0] IR,
  output logic           IRload,
  output logic           JMPmux,
  output logic           PCload,
  output logic           Meminst,
  output logic           MemWr,
  output logic           Aload,
  output logic           Sub,
  output logic           Halt,
  output logic [1:0]     Asel,
  output logic           illegal_op,
  output logic [3:0]     state_o
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_IN     = 4'd7,
    S_JZ     = 4'd8,
    S_JPOS   = 4'd9,
    S_HALT   = 4'd10,
    S_JMP    = 4'd11,
    S_NOP    = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_LOAD  = OPW'(0);
  localparam logic [OPW-1:0] OP_STORE = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(3);
  localparam logic [OPW-1:0] OP_IN    = OPW'(4);
  localparam logic [OPW-1:0] OP_JZ    = OPW'(5);
  localparam logic [OPW-1:0] OP_JPOS  = OPW'(6);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(7);
  localparam logic [OPW-1:0] OP_JMP   = OPW'(8);
  localparam logic [OPW-1:0] OP_NOP   = OPW'(9);
  localparam logic [OPW-1:0] OP_ILL   = OPW'(10);

  // MEM_LAT=0 still needs a 1-bit counter; it simply never leaves 0.
  localparam int             CW       = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_LAT);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          enter_q;
  logic          last;
  logic          enter_edge;
  logic          op_bad;

  assign last       = (cnt == CNT_LAST);
  assign enter_edge = Enter & ~enter_q;
  assign op_bad     = (IR >= OP_ILL);
  assign state_o    = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_START;
      cnt        <= '0;
      enter_q    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state   <= state_nxt;
      enter_q <= Enter;
      // Counter restarts on every state change so each multi-cycle state
      // sees 0..MEM_LAT; it saturates in states that idle.
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (!last) begin
        cnt <= cnt + 1'b1;
      end
      if (state == S_DECODE && op_bad) begin
        illegal_op <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    IRload    = 1'b0;
    JMPmux    = 1'b0;
    PCload    = 1'b0;
    Meminst   = 1'b0;
    MemWr     = 1'b0;
    Aload     = 1'b0;
    Sub       = 1'b0;
    Halt      = 1'b0;
    Asel      = 2'b00;

    case (state)
      S_START: state_nxt = S_FETCH;
      S_FETCH: begin
        Meminst = 1'b1;
        if (last) begin
          IRload    = 1'b1;
          PCload    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (IR)
          OP_LOAD:  state_nxt = S_LOAD;
          OP_STORE: state_nxt = S_STORE;
          OP_ADD:   state_nxt = S_ADD;
          OP_SUB:   state_nxt = S_SUB;
          OP_IN:    state_nxt = S_IN;
          OP_JZ:    state_nxt = S_JZ;
          OP_JPOS:  state_nxt = S_JPOS;
          OP_HALT:  state_nxt = S_HALT;
          OP_JMP:   state_nxt = S_JMP;
          OP_NOP:   state_nxt = S_NOP;
          default:  state_nxt = S_HALT;  // illegal opcode traps
        endcase
      end
      S_LOAD: begin
        Asel = 2'b10;
        if (last) begin
          Aload     = 1'b1;
          state_nxt = S_START;
        end
      end
      S_STORE: begin
        MemWr     = 1'b1;
        state_nxt = S_START;
      end
      S_ADD, S_SUB: begin
        Asel = 2'b00;
        Sub  = (state == S_SUB);
        if (last) begin
          Aload     = 1'b1;
          state_nxt = S_START;
        end
      end
      S_IN: begin
        Asel = 2'b01;
        // Only a fresh press counts; a switch already high on entry is ignored.
        if (enter_edge) begin
          Aload     = 1'b1;
          state_nxt = S_START;
        end
      end
      S_JZ: begin
        JMPmux    = Aeq0;
        PCload    = Aeq0;
        state_nxt = S_START;
      end
      S_JPOS: begin
        JMPmux    = Apos;
        PCload    = Apos;
        state_nxt = S_START;
      end
      S_JMP: begin
        JMPmux    = 1'b1;
        PCload    = 1'b1;
        state_nxt = S_START;
      end
      S_NOP: state_nxt = S_START;
      S_HALT: begin
        Halt = 1'b1;
        if (RESUME_EN != 0 && enter_edge) begin
          state_nxt = S_START;
        end
      end
      default: state_nxt = S_START;
    endcase
  end

endmodule

// File: tb/tb_cu_param.sv
module tb_cu_param;

  logic       clock;
  logic       reset;
  logic       Enter;
  logic       Aeq0;
  logic       Apos;
  logic [3:0] IR;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic       illegal_op;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  // Output vector bit positions: {IRload,JMPmux,PCload,Meminst,MemWr,Aload,Sub,Halt,Asel[1:0],illegal_op}
  localparam logic [10:0] NONE   = 11'h000;
  localparam logic [10:0] IRL    = 11'h400;
  localparam logic [10:0] JMX    = 11'h200;
  localparam logic [10:0] PCL    = 11'h100;
  localparam logic [10:0] MEMI   = 11'h080;
  localparam logic [10:0] MWR    = 11'h040;
  localparam logic [10:0] ALD    = 11'h020;
  localparam logic [10:0] SUBB   = 11'h010;
  localparam logic [10:0] HLT    = 11'h008;
  localparam logic [10:0] AS_MEM = 11'h004;
  localparam logic [10:0] AS_IN  = 11'h002;
  localparam logic [10:0] ILL    = 11'h001;

  cu_param #(.OPW(4), .MEM_LAT(2), .RESUME_EN(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .Enter      (Enter),
    .Aeq0       (Aeq0),
    .Apos       (Apos),
    .IR         (IR),
    .IRload     (IRload),
    .JMPmux     (JMPmux),
    .PCload     (PCload),
    .Meminst    (Meminst),
    .MemWr      (MemWr),
    .Aload      (Aload),
    .Sub        (Sub),
    .Halt       (Halt),
    .Asel       (Asel),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_st, input logic [10:0] exp_o);
    logic [10:0] obs;
    obs = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Asel, illegal_op};
    checks++;
    assert (state_o === exp_st) else begin
      errors++;
      $error("FAIL %s state observed %0d expected %0d", tag, state_o, exp_st);
    end
    checks++;
    assert (obs === exp_o) else begin
      errors++;
      $error("FAIL %s outputs observed %03h expected %03h", tag, obs, exp_o);
    end
  endtask

  // START -> FETCH x3 -> DECODE, checked cycle by cycle.
  task automatic fetch_decode(input string tag, input logic [10:0] sticky);
    step(); chk({tag, "_f0"}, 4'd1, MEMI | sticky);
    step(); chk({tag, "_f1"}, 4'd1, MEMI | sticky);
    step(); chk({tag, "_f2"}, 4'd1, MEMI | IRL | PCL | sticky);
    step(); chk({tag, "_dec"}, 4'd2, sticky);
  endtask

  initial begin
    reset = 1'b1; Enter = 1'b0; Aeq0 = 1'b0; Apos = 1'b0; IR = 4'd0;

    // Reset state
    step(); chk("rst1", 4'd0, NONE);
    step(); chk("rst2", 4'd0, NONE);
    reset = 1'b0;

    // LOAD with 2 wait states
    fetch_decode("load", NONE);
    step(); chk("load_c0", 4'd3, AS_MEM);
    step(); chk("load_c1", 4'd3, AS_MEM);
    step(); chk("load_c2", 4'd3, AS_MEM | ALD);
    step(); chk("load_done", 4'd0, NONE);

    // ADD and SUB
    IR = 4'd2;
    fetch_decode("add", NONE);
    step(); chk("add_c0", 4'd5, NONE);
    step(); chk("add_c1", 4'd5, NONE);
    step(); chk("add_c2", 4'd5, ALD);
    step(); chk("add_done", 4'd0, NONE);
    IR = 4'd3;
    fetch_decode("sub", NONE);
    step(); chk("sub_c0", 4'd6, SUBB);
    step(); chk("sub_c2pre", 4'd6, SUBB);
    step(); chk("sub_c2", 4'd6, SUBB | ALD);
    step(); chk("sub_done", 4'd0, NONE);

    // IN: Enter held high on entry is ignored, a fresh press loads A
    IR = 4'd4; Enter = 1'b1;
    fetch_decode("in", NONE);
    step(); chk("in_held0", 4'd7, AS_IN);
    step(); chk("in_held1", 4'd7, AS_IN);
    Enter = 1'b0;
    step(); chk("in_released", 4'd7, AS_IN);
    Enter = 1'b1; #1;
    chk("in_edge", 4'd7, AS_IN | ALD);
    step(); chk("in_done", 4'd0, NONE);
    Enter = 1'b0;

    // JZ taken / not taken
    IR = 4'd5; Aeq0 = 1'b1;
    fetch_decode("jz", NONE);
    step(); chk("jz_taken", 4'd8, JMX | PCL);
    Aeq0 = 1'b0; #1;
    chk("jz_not", 4'd8, NONE);
    step(); chk("jz_done", 4'd0, NONE);

    // JPOS taken / not taken
    IR = 4'd6; Apos = 1'b1;
    fetch_decode("jpos", NONE);
    step(); chk("jpos_taken", 4'd9, JMX | PCL);
    Apos = 1'b0; #1;
    chk("jpos_not", 4'd9, NONE);
    step(); chk("jpos_done", 4'd0, NONE);

    // JMP always, NOP nothing
    IR = 4'd8;
    fetch_decode("jmp", NONE);
    step(); chk("jmp", 4'd11, JMX | PCL);
    step(); chk("jmp_done", 4'd0, NONE);
    IR = 4'd9;
    fetch_decode("nop", NONE);
    step(); chk("nop", 4'd12, NONE);
    step(); chk("nop_done", 4'd0, NONE);

    // Illegal opcode traps to HALT, Enter edge resumes, flag stays
    IR = 4'd12;
    fetch_decode("ill", NONE);
    step(); chk("ill_halt0", 4'd10, HLT | ILL);
    step(); chk("ill_halt1", 4'd10, HLT | ILL);
    Enter = 1'b1;
    step(); chk("ill_resume", 4'd0, ILL);
    Enter = 1'b0;

    // STORE, then reset in the STORE cycle
    IR = 4'd1;
    fetch_decode("store", ILL);
    step(); chk("store", 4'd4, MWR | ILL);
    reset = 1'b1;
    step(); chk("store_rst", 4'd0, NONE);
    reset = 1'b0;
    step(); chk("after_rst", 4'd1, MEMI);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
